// File: rtl/decoder_pkg.sv
// Shared types and limits for the sequenced one-hot decoder.
package decoder_pkg;

   localparam int MODE_W     = 2;
   localparam int STAGES_MAX = 4;

   typedef enum logic [MODE_W-1:0] {
      CLEAR   = 2'b00,
      LOAD    = 2'b01,
      STEP_UP = 2'b10,
      STEP_DN = 2'b11
   } mode_t;

endpackage

// File: rtl/decoder_n.sv
// Combinational enabled SEL_W:2**SEL_W decoder, built recursively from 1:2 decoders.
module decoder_n #(
   parameter int SEL_W = 1
) (
   input  logic                en,
   input  logic [SEL_W-1:0]    sel,
   output logic [2**SEL_W-1:0] dec
);

   if (SEL_W == 1) begin : g_leaf
      assign dec = en ? {sel[0], ~sel[0]} : 2'b00;
   end else begin : g_split
      logic [1:0] half_en;

      // The MSB picks which half is enabled; each half decodes the remaining bits.
      decoder_n #(.SEL_W(1)) u_msb (
         .en  (en),
         .sel (sel[SEL_W-1]),
         .dec (half_en)
      );

      decoder_n #(.SEL_W(SEL_W-1)) u_lo (
         .en  (half_en[0]),
         .sel (sel[SEL_W-2:0]),
         .dec (dec[2**(SEL_W-1)-1:0])
      );

      decoder_n #(.SEL_W(SEL_W-1)) u_hi (
         .en  (half_en[1]),
         .sel (sel[SEL_W-2:0]),
         .dec (dec[2**SEL_W-1:2**(SEL_W-1)])
      );
   end

endmodule

// File: rtl/decoder_seq_onehot.sv
// Registered one-hot decoder with load/clear/rotate modes, stall, and optional output retiming.
module decoder_seq_onehot
   import decoder_pkg::*;
#(
   parameter int SEL_W  = 3,
   parameter int STAGES = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                en,
   input  mode_t               mode,
   input  logic [SEL_W-1:0]    sel,
   input  logic                stall,
   output logic [2**SEL_W-1:0] out,
   output logic                out_valid,
   output logic [SEL_W-1:0]    idx,
   output logic                wrap
);

   localparam int OUT_W = 2**SEL_W;
   localparam logic [OUT_W-1:0] LSB_ONE = {{(OUT_W-1){1'b0}}, 1'b1};

   if (STAGES < 1 || STAGES > STAGES_MAX) begin : g_bad_stages
      $error("decoder_seq_onehot: STAGES=%0d outside 1..%0d", STAGES, STAGES_MAX);
   end

   logic [OUT_W-1:0] load_dec;
   logic [OUT_W-1:0] state_q, state_d;
   logic             wrap_q, wrap_d;

   decoder_n #(.SEL_W(SEL_W)) u_load_dec (
      .en  (en),
      .sel (sel),
      .dec (load_dec)
   );

   always_comb begin
      state_d = state_q;
      wrap_d  = wrap_q;
      if (!stall) begin
         case (mode)
            CLEAR: begin
               state_d = '0;
               wrap_d  = 1'b0;
            end
            LOAD: begin
               state_d = load_dec;
               wrap_d  = 1'b0;
            end
            // A zero state rotates to zero and never reports a wrap.
            STEP_UP: begin
               state_d = {state_q[OUT_W-2:0], state_q[OUT_W-1]};
               wrap_d  = state_q[OUT_W-1];
            end
            STEP_DN: begin
               state_d = {state_q[0], state_q[OUT_W-1:1]};
               wrap_d  = state_q[0];
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wrap_q  <= wrap_d;
      end
   end

   logic [OUT_W-1:0] chain_state [STAGES];
   logic             chain_wrap  [STAGES];

   assign chain_state[0] = state_q;
   assign chain_wrap[0]  = wrap_q;

   for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
      logic [OUT_W-1:0] st_q;
      logic             wr_q;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            st_q <= '0;
            wr_q <= 1'b0;
         end else if (!stall) begin
            st_q <= chain_state[gi-1];
            wr_q <= chain_wrap[gi-1];
         end
      end

      assign chain_state[gi] = st_q;
      assign chain_wrap[gi]  = wr_q;
   end

   assign out       = chain_state[STAGES-1];
   assign wrap      = chain_wrap[STAGES-1];
   assign out_valid = (out != '0) && ((out & (out - LSB_ONE)) == '0);

   // OR-tree encoder: index bit gi is the OR of every line whose number has bit gi set.
   logic [SEL_W-1:0] idx_raw;

   for (genvar gi = 0; gi < SEL_W; gi++) begin : g_enc
      logic [OUT_W-1:0] mask;
      for (genvar gj = 0; gj < OUT_W; gj++) begin : g_mask
         assign mask[gj] = 1'((gj >> gi) & 1);
      end
      assign idx_raw[gi] = |(out & mask);
   end

   assign idx = out_valid ? idx_raw : '0;

endmodule
